// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter and byte sequencer between I-fetch, D-side and a byte-wide memory
module mem_arbiter (
   input  logic        clock,
   input  logic        reset,
   input  logic        i_read,
   input  logic [31:0] i_address,
   output logic [31:0] i_readdata,
   output logic        i_busywait,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [31:0] d_address,
   input  logic [31:0] d_writedata,
   input  logic [2:0]  d_funct3,
   output logic [31:0] d_readdata,
   output logic        d_busywait,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_address,
   output logic [7:0]  mem_writedata,
   input  logic [7:0]  mem_readdata,
   input  logic        mem_busywait
);
   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
   state_t      state;
   logic        gnt;
   logic        last;
   logic        sgn;
   logic        wr;
   logic [2:0]  n;
   logic [2:0]  k;
   logic [31:0] wdata;
   logic [31:0] rbuf;
   logic [31:0] rnext;
   logic [31:0] rext;
   logic        d_req;
   logic        pick_d;
   logic        illegal;
   logic        done_byte;
   logic        last_byte;
   logic [2:0]  d_n;

   // gnt/last encoding: 0 = I-side, 1 = D-side; a store wins when read and write are both high
   assign d_req     = d_read | d_write;
   assign pick_d    = d_req & (~i_read | ~last);
   assign illegal   = (d_funct3 == 3'b011) || (d_funct3[2:1] == 2'b11);
   assign d_n       = d_funct3[1] ? 3'd4 : d_funct3[0] ? 3'd2 : 3'd1;
   assign done_byte = (mem_read | mem_write) & ~mem_busywait;
   assign last_byte = k == n - 3'd1;
   assign i_busywait = i_read & ~(state == DONE && !gnt);
   assign d_busywait = d_req & ~(state == DONE && gnt);

   // merge the byte arriving this cycle into the assembly buffer
   always_comb begin
      rnext = rbuf;
      rnext[{k[1:0], 3'b000} +: 8] = mem_readdata;
   end

   // extend the assembled load to 32 bits by size and signedness
   always_comb begin
      rext = (n == 3'd1) ? {{24{sgn & rnext[7]}}, rnext[7:0]} :
             (n == 3'd2) ? {{16{sgn & rnext[15]}}, rnext[15:0]} : rnext;
   end

   // arbitration FSM; memory strobes, address and write byte are registered here
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         gnt           <= 1'b0;
         last          <= 1'b1;
         sgn           <= 1'b0;
         wr            <= 1'b0;
         n             <= 3'd0;
         k             <= 3'd0;
         wdata         <= 32'd0;
         rbuf          <= 32'd0;
         mem_read      <= 1'b0;
         mem_write     <= 1'b0;
         mem_address   <= 32'd0;
         mem_writedata <= 8'd0;
         i_readdata    <= 32'd0;
         d_readdata    <= 32'd0;
      end else begin
         case (state)
            IDLE: if (i_read | d_req) begin
               gnt  <= pick_d;
               k    <= 3'd0;
               rbuf <= 32'd0;
               if (pick_d) begin
                  sgn           <= ~d_funct3[2];
                  wr            <= d_write;
                  n             <= d_n;
                  wdata         <= d_writedata;
                  mem_address   <= d_address;
                  mem_writedata <= d_writedata[7:0];
                  if (illegal) begin
                     d_readdata <= 32'd0;
                     state      <= DONE;
                  end else begin
                     mem_read  <= ~d_write;
                     mem_write <= d_write;
                     state     <= XFER;
                  end
               end else begin
                  sgn           <= 1'b0;
                  wr            <= 1'b0;
                  n             <= 3'd4;
                  wdata         <= 32'd0;
                  mem_address   <= i_address;
                  mem_writedata <= 8'd0;
                  mem_read      <= 1'b1;
                  state         <= XFER;
               end
            end
            XFER: if (done_byte) begin
               rbuf <= rnext;
               k    <= k + 3'd1;
               if (last_byte) begin
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  state     <= DONE;
                  if (!wr) begin
                     if (gnt) d_readdata <= rext;
                     else i_readdata <= rext;
                  end
               end else begin
                  mem_address   <= mem_address + 32'd1;
                  mem_writedata <= wdata[{k[1:0] + 2'd1, 3'b000} +: 8];
               end
            end
            DONE: begin
               last  <= gnt;
               k     <= 3'd0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
   logic        clock = 1'b0;
   logic        reset;
   logic        i_read;
   logic [31:0] i_address;
   logic [31:0] i_readdata;
   logic        i_busywait;
   logic        d_read;
   logic        d_write;
   logic [31:0] d_address;
   logic [31:0] d_writedata;
   logic [2:0]  d_funct3;
   logic [31:0] d_readdata;
   logic        d_busywait;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_address;
   logic [7:0]  mem_writedata;
   logic [7:0]  mem_readdata;
   logic        mem_busywait;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  mem [256];
   logic        stall_en = 1'b0;
   int          scnt = 0;
   logic [31:0] wa [64];
   logic [7:0]  wdl [64];
   int          wn = 0;
   int          rn = 0;

   mem_arbiter dut (
      .clock(clock), .reset(reset),
      .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
      .d_funct3(d_funct3), .d_readdata(d_readdata), .d_busywait(d_busywait),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
   );

   always #5 clock = ~clock;

   // memory model: 256-byte window, optional 2-cycle stall on every byte
   assign mem_readdata = mem[mem_address[7:0]];
   assign mem_busywait = stall_en & (mem_read | mem_write) & (scnt < 2);

   // stall counter and log of completed byte writes / reads
   always @(posedge clock) begin
      scnt <= ((mem_read | mem_write) && mem_busywait) ? scnt + 1 : 0;
      if (mem_write && !mem_busywait) begin
         wa[wn[5:0]]  <= mem_address;
         wdl[wn[5:0]] <= mem_writedata;
         wn           <= wn + 1;
      end
      if (mem_read && !mem_busywait) rn <= rn + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic d_op(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, output int cyc);
      d_read = rd;
      d_write = wr;
      d_funct3 = f3;
      d_address = a;
      d_writedata = wd;
      cyc = 0;
      do begin
         @(negedge clock);
         cyc++;
      end while (d_busywait && cyc < 50);
      d_read = 1'b0;
      d_write = 1'b0;
      @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int w0;
      int r0;
      logic [31:0] wv;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h00] = 8'h78; mem[8'h01] = 8'h56; mem[8'h02] = 8'h34; mem[8'h03] = 8'h12;
      mem[8'h10] = 8'h80; mem[8'h11] = 8'h11; mem[8'h12] = 8'h22; mem[8'h13] = 8'h33;
      mem[8'h20] = 8'h34; mem[8'h21] = 8'h82;
      reset = 1'b0;
      i_read = 1'b0;
      i_address = 32'd0;
      d_read = 1'b0;
      d_write = 1'b0;
      d_address = 32'd0;
      d_writedata = 32'd0;
      d_funct3 = 3'd0;
      @(negedge clock);
      @(negedge clock);
      check("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
      check("rst_addr", mem_address, 32'd0);
      check("rst_wdata", {24'd0, mem_writedata}, 32'd0);
      check("rst_ird", i_readdata, 32'd0);
      check("rst_drd", d_readdata, 32'd0);
      reset = 1'b1;

      // I-side word fetch, zero-wait
      i_read = 1'b1;
      i_address = 32'h100;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clock);
         check("if_rd", {31'd0, mem_read}, 32'd1);
         check("if_addr", mem_address, 32'h100 + c - 1);
         check("if_busy", {31'd0, i_busywait}, 32'd1);
      end
      @(negedge clock);
      check("if_done", {31'd0, i_busywait}, 32'd0);
      check("if_data", i_readdata, 32'h12345678);
      i_read = 1'b0;
      @(negedge clock);

      // loads with sign/zero extension
      d_op(1'b1, 1'b0, 3'b000, 32'h10, 32'd0, cyc);
      check("lb_cyc", cyc, 32'd2);
      check("lb_data", d_readdata, 32'hFFFFFF80);
      d_op(1'b1, 1'b0, 3'b100, 32'h10, 32'd0, cyc);
      check("lbu_data", d_readdata, 32'h00000080);
      d_op(1'b1, 1'b0, 3'b001, 32'h20, 32'd0, cyc);
      check("lh_cyc", cyc, 32'd3);
      check("lh_data", d_readdata, 32'hFFFF8234);
      d_op(1'b1, 1'b0, 3'b101, 32'h20, 32'd0, cyc);
      check("lhu_data", d_readdata, 32'h00008234);
      r0 = rn;
      d_op(1'b1, 1'b0, 3'b010, 32'h10, 32'd0, cyc);
      check("lw_cyc", cyc, 32'd5);
      check("lw_data", d_readdata, 32'h33221180);
      check("lw_nbytes", rn - r0, 32'd4);
      check("i_hold", i_readdata, 32'h12345678);

      // illegal funct3: no access, one cycle, result zero
      r0 = rn;
      d_op(1'b1, 1'b0, 3'b011, 32'h10, 32'd0, cyc);
      check("ill_cyc", cyc, 32'd1);
      check("ill_data", d_readdata, 32'd0);
      check("ill_nbytes", rn - r0, 32'd0);

      // SH wrapping past the top of the address space
      w0 = wn;
      d_op(1'b0, 1'b1, 3'b001, 32'hFFFFFFFF, 32'hAABBCCDD, cyc);
      check("sh_cyc", cyc, 32'd3);
      check("sh_nwr", wn - w0, 32'd2);
      check("sh_a0", wa[w0], 32'hFFFFFFFF);
      check("sh_d0", {24'd0, wdl[w0]}, 32'hDD);
      check("sh_a1", wa[w0 + 1], 32'h00000000);
      check("sh_d1", {24'd0, wdl[w0 + 1]}, 32'hCC);

      // SW with two stall cycles per byte
      stall_en = 1'b1;
      wv = 32'h11223344;
      d_write = 1'b1;
      d_funct3 = 3'b010;
      d_address = 32'h40;
      d_writedata = wv;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clock);
         check("sw_wr", {31'd0, mem_write}, 32'd1);
         check("sw_addr", mem_address, 32'h40 + (c - 1) / 3);
         check("sw_data", {24'd0, mem_writedata}, {24'd0, 8'(wv >> (8 * ((c - 1) / 3)))});
         check("sw_busy", {31'd0, d_busywait}, 32'd1);
      end
      @(negedge clock);
      check("sw_done", {31'd0, d_busywait}, 32'd0);
      d_write = 1'b0;
      stall_en = 1'b0;
      @(negedge clock);

      // contention right after reset: I, then D, then I
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      i_read = 1'b1;
      i_address = 32'h100;
      d_read = 1'b1;
      d_funct3 = 3'b010;
      d_address = 32'h10;
      for (int c = 1; c <= 13; c++) begin
         @(negedge clock);
         if (c <= 4) begin
            check("ct_iaddr", mem_address, 32'h100 + c - 1);
            check("ct_dbusy", {31'd0, d_busywait}, 32'd1);
         end
         if (c == 5) begin
            check("ct_idone", {30'd0, i_busywait, d_busywait}, 32'd1);
            check("ct_idata", i_readdata, 32'h12345678);
         end
         if (c == 6) check("ct_idle", {30'd0, mem_read, mem_write}, 32'd0);
         if (c >= 7 && c <= 10) begin
            check("ct_daddr", mem_address, 32'h10 + c - 7);
            check("ct_ibusy", {31'd0, i_busywait}, 32'd1);
         end
         if (c == 11) begin
            check("ct_ddone", {30'd0, i_busywait, d_busywait}, 32'd2);
            check("ct_ddata", d_readdata, 32'h33221180);
         end
         if (c == 13) begin
            check("ct_iagain", mem_address, 32'h100);
            check("ct_iagain_rd", {31'd0, mem_read}, 32'd1);
         end
      end
      i_read = 1'b0;
      d_read = 1'b0;
      for (int c = 0; c < 6; c++) @(negedge clock);

      // asynchronous reset in the middle of an LW
      d_read = 1'b1;
      d_funct3 = 3'b010;
      d_address = 32'h0;
      @(negedge clock);
      @(negedge clock);
      check("mr_addr", mem_address, 32'h1);
      #2 reset = 1'b0;
      #1;
      check("mr_strobes", {30'd0, mem_read, mem_write}, 32'd0);
      check("mr_maddr", mem_address, 32'd0);
      check("mr_ird", i_readdata, 32'd0);
      check("mr_drd", d_readdata, 32'd0);
      d_read = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      d_op(1'b1, 1'b0, 3'b010, 32'h0, 32'd0, cyc);
      check("mr_cyc", cyc, 32'd5);
      check("mr_data", d_readdata, 32'h12345678);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
